// File: rtl/program_seq_pkg.sv
// Shared encodings for the program sequencer: opcodes, ALU ops, FSM states, decoded control.
package program_seq_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LOAD = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_SUBI = 4'hB;
  localparam logic [3:0] OP_BR   = 4'hC;
  localparam logic [3:0] OP_MOV  = 4'hE;
  localparam logic [3:0] OP_OUT  = 4'hF;

  localparam logic [1:0] ALU_PASS_IMM = 2'b00;
  localparam logic [1:0] ALU_ADD      = 2'b01;
  localparam logic [1:0] ALU_SUB      = 2'b10;
  localparam logic [1:0] ALU_PASS_RS  = 2'b11;

  typedef enum logic {FETCH = 1'b0, EXEC = 1'b1} state_t;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       src_imm;
    logic       reg_we;
    logic       flag_we;
    logic       out_en;
    logic       is_jmp;
    logic       is_br;
    logic       is_illegal;
  } ctrl_t;

endpackage

// File: rtl/program_sequencer_inst_decoder.sv
// Combinational opcode decode; strobes are raw here and get state-qualified by the sequencer.
module inst_decoder
  import program_seq_pkg::*;
(
  input  logic [3:0] opcode,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (opcode)
      OP_NOP: ;
      OP_LOAD: begin
        ctrl.reg_we  = 1'b1;
        ctrl.alu_op  = ALU_PASS_IMM;
        ctrl.src_imm = 1'b1;
      end
      OP_ADD: begin
        ctrl.reg_we  = 1'b1;
        ctrl.flag_we = 1'b1;
        ctrl.alu_op  = ALU_ADD;
      end
      OP_SUB: begin
        ctrl.reg_we  = 1'b1;
        ctrl.flag_we = 1'b1;
        ctrl.alu_op  = ALU_SUB;
      end
      OP_SUBI: begin
        ctrl.reg_we  = 1'b1;
        ctrl.flag_we = 1'b1;
        ctrl.alu_op  = ALU_SUB;
        ctrl.src_imm = 1'b1;
      end
      OP_MOV: begin
        ctrl.reg_we = 1'b1;
        ctrl.alu_op = ALU_PASS_RS;
      end
      OP_OUT:  ctrl.out_en = 1'b1;
      OP_JMP:  ctrl.is_jmp = 1'b1;
      OP_BR:   ctrl.is_br  = 1'b1;
      default: ctrl.is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/program_sequencer.sv
// Two-cycle fetch/execute controller: owns pc and IR, issues one EXEC cycle of strobes.
// Optional SINGLE_STEP_EN adds a step input; FETCH then advances once per rising step edge.
module program_sequencer
  import program_seq_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int INST_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
`ifdef SINGLE_STEP_EN
  input  logic              step,
`endif
  input  logic [INST_W-1:0] instruction,
  input  logic              zero_flag,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [ADDR_W-1:0] pc,
  output logic [2:0]        rd_sel,
  output logic [2:0]        rs_sel,
  output logic [7:0]        imm,
  output logic [1:0]        alu_op,
  output logic              src_imm,
  output logic              reg_we,
  output logic              flag_we,
  output logic              out_en,
  output logic              illegal,
  output logic [CNT_W-1:0]  instr_count
);

  state_t              state, state_nxt;
  logic [INST_W-1:0]   ir;
  logic [ADDR_W-1:0]   next_pc;
  logic                fetch_go;
  logic                exec_q;
  ctrl_t               ctrl;

  inst_decoder u_dec (
    .opcode (ir[15:12]),
    .ctrl   (ctrl)
  );

`ifdef SINGLE_STEP_EN
  logic step_q;
  always_ff @(posedge clk) begin
    if (rst) step_q <= 1'b0;
    else     step_q <= step;
  end
  wire step_rise = step & ~step_q;
`else
  wire step_rise = 1'b1;
`endif

  always_comb begin
    state_nxt = state;
    fetch_go  = 1'b0;
    case (state)
      FETCH: if (run && step_rise) begin
        fetch_go  = 1'b1;
        state_nxt = EXEC;
      end
      EXEC:    state_nxt = FETCH;
      default: state_nxt = FETCH;
    endcase
  end

  // br samples zero_flag in its own EXEC cycle, so the previous instruction's flag write is seen
  always_comb begin
    next_pc = pc + 1'b1;
    if (ctrl.is_jmp || (ctrl.is_br && zero_flag))
      next_pc = ir[8 +: ADDR_W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= '0;
      ir          <= '0;
      illegal     <= 1'b0;
      instr_count <= '0;
    end else begin
      state <= state_nxt;
      if (fetch_go) ir <= instruction;
      if (state == EXEC) begin
        pc          <= next_pc;
        instr_count <= instr_count + 1'b1;
        if (ctrl.is_illegal) illegal <= 1'b1;
      end
    end
  end

  // rst gates strobes combinationally so a reset landing in EXEC kills them that cycle
  assign exec_q   = (state == EXEC) && !rst;
  assign reg_we   = exec_q & ctrl.reg_we;
  assign flag_we  = exec_q & ctrl.flag_we;
  assign out_en   = exec_q & ctrl.out_en;
  assign alu_op   = ctrl.alu_op;
  assign src_imm  = ctrl.src_imm;
  assign rom_addr = pc;
  assign rd_sel   = ir[11:9];
  assign rs_sel   = ir[8:6];
  assign imm      = ir[7:0];

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer with a bench-owned ROM and an expectation queue.
module tb_program_sequencer;

  logic        clk, rst, run, zero_flag;
  logic [15:0] instruction;
  logic [3:0]  rom_addr, pc;
  logic [2:0]  rd_sel, rs_sel;
  logic [7:0]  imm;
  logic [1:0]  alu_op;
  logic        src_imm, reg_we, flag_we, out_en, illegal;
  logic [7:0]  instr_count;
`ifdef SINGLE_STEP_EN
  logic        step;
`endif

  logic [15:0] rom [16];
  assign instruction = rom[rom_addr];

  program_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
`ifdef SINGLE_STEP_EN
    .step        (step),
`endif
    .instruction (instruction),
    .zero_flag   (zero_flag),
    .rom_addr    (rom_addr),
    .pc          (pc),
    .rd_sel      (rd_sel),
    .rs_sel      (rs_sel),
    .imm         (imm),
    .alu_op      (alu_op),
    .src_imm     (src_imm),
    .reg_we      (reg_we),
    .flag_we     (flag_we),
    .out_en      (out_en),
    .illegal     (illegal),
    .instr_count (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  string       tag_q[$];
  logic [31:0] exp_q[$];

  task automatic push(input string t, input int v);
    tag_q.push_back(t);
    exp_q.push_back(32'(v));
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %0h expected <none>", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", t, obs, e);
      end
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_step(input logic v);
`ifdef SINGLE_STEP_EN
    step = v;
`endif
  endtask

  // one full fetch+exec; -1 marks a field as don't-care
  task automatic run_instr(input string nm, input int addr, input int we, input int fwe,
                           input int oe, input int aop, input int simm, input int erd,
                           input int ers, input int eimm, input int npc, input int cnt,
                           input int ill);
    push({nm, ".rom_addr"}, addr);
    push({nm, ".fetch_we"}, 0);
    push({nm, ".reg_we"}, we);
    push({nm, ".flag_we"}, fwe);
    push({nm, ".out_en"}, oe);
    if (aop >= 0)  push({nm, ".alu_op"}, aop);
    if (simm >= 0) push({nm, ".src_imm"}, simm);
    if (erd >= 0)  push({nm, ".rd_sel"}, erd);
    if (ers >= 0)  push({nm, ".rs_sel"}, ers);
    if (eimm >= 0) push({nm, ".imm"}, eimm);
    push({nm, ".pc"}, npc);
    push({nm, ".count"}, cnt);
    push({nm, ".illegal"}, ill);
    pop_chk(32'(rom_addr));
    pop_chk(32'(reg_we));
    set_step(1'b1);
    tick;
    set_step(1'b0);
    pop_chk(32'(reg_we));
    pop_chk(32'(flag_we));
    pop_chk(32'(out_en));
    if (aop >= 0)  pop_chk(32'(alu_op));
    if (simm >= 0) pop_chk(32'(src_imm));
    if (erd >= 0)  pop_chk(32'(rd_sel));
    if (ers >= 0)  pop_chk(32'(rs_sel));
    if (eimm >= 0) pop_chk(32'(imm));
    tick;
    pop_chk(32'(pc));
    pop_chk(32'(instr_count));
    pop_chk(32'(illegal));
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; zero_flag = 1'b0;
    set_step(1'b0);
    for (int i = 0; i < 16; i++) rom[i] = 16'h0000;
    rom[0]  = 16'h1201;  // load r1, 1
    rom[1]  = 16'h2280;  // add r1, r2
    rom[2]  = 16'hF200;  // out r1
    rom[3]  = 16'hB205;  // subi r1, 5
    rom[4]  = 16'hCA00;  // br 10
    rom[5]  = 16'hE280;  // mov r1, r2
    rom[6]  = 16'h8300;  // jmp 3
    rom[10] = 16'h8F00;  // jmp 15
    rom[15] = 16'h4000;  // undefined

    tick; tick;
    push("rst.pc", 0); push("rst.count", 0); push("rst.illegal", 0);
    push("rst.reg_we", 0); push("rst.out_en", 0);
    pop_chk(32'(pc)); pop_chk(32'(instr_count)); pop_chk(32'(illegal));
    pop_chk(32'(reg_we)); pop_chk(32'(out_en));

    rst = 1'b0; run = 1'b1;
    run_instr("load",   0, 1, 0, 0,  0,  1,  1, -1,  1,  1, 1, 0);
    run_instr("add",    1, 1, 1, 0,  1,  0,  1,  2, -1,  2, 2, 0);
    run_instr("out",    2, 0, 0, 1, -1, -1,  1, -1, -1,  3, 3, 0);
    run_instr("subi",   3, 1, 1, 0,  2,  1,  1, -1,  5,  4, 4, 0);
    zero_flag = 1'b1;
    run_instr("br_tk",  4, 0, 0, 0, -1, -1, -1, -1, -1, 10, 5, 0);
    run_instr("jmp15", 10, 0, 0, 0, -1, -1, -1, -1, -1, 15, 6, 0);
    run_instr("undef", 15, 0, 0, 0, -1, -1, -1, -1, -1,  0, 7, 1);
    zero_flag = 1'b0;
    run_instr("load2",  0, 1, 0, 0,  0,  1,  1, -1,  1,  1, 8, 1);
    run_instr("add2",   1, 1, 1, 0,  1,  0,  1,  2, -1,  2, 9, 1);
    run_instr("out2",   2, 0, 0, 1, -1, -1, -1, -1, -1,  3, 10, 1);
    run_instr("subi2",  3, 1, 1, 0,  2,  1, -1, -1, -1,  4, 11, 1);
    run_instr("br_nt",  4, 0, 0, 0, -1, -1, -1, -1, -1,  5, 12, 1);
    run_instr("mov",    5, 1, 0, 0,  3, -1,  1,  2, -1,  6, 13, 1);
    run_instr("jmp3",   6, 0, 0, 0, -1, -1, -1, -1, -1,  3, 14, 1);

    // run low in FETCH: everything frozen, IR still holds jmp 3 (imm=0)
    run = 1'b0;
    push("hold.pc", 3); push("hold.count", 14); push("hold.imm", 0); push("hold.reg_we", 0);
    repeat (5) tick;
    pop_chk(32'(pc)); pop_chk(32'(instr_count)); pop_chk(32'(imm)); pop_chk(32'(reg_we));

    // run dropped during EXEC: subi still completes, then holds
    run = 1'b1;
    push("drop.exec_we", 1); push("drop.pc", 4); push("drop.count", 15);
    push("drop.hold_pc", 4); push("drop.hold_count", 15);
    set_step(1'b1);
    tick;
    set_step(1'b0);
    run = 1'b0;
    pop_chk(32'(reg_we));
    tick;
    pop_chk(32'(pc)); pop_chk(32'(instr_count));
    tick; tick;
    pop_chk(32'(pc)); pop_chk(32'(instr_count));

    // reset landing in EXEC of add
    rom[4] = 16'h2280;
    run = 1'b1;
    push("rstx.exec_we", 1); push("rstx.reg_we", 0); push("rstx.flag_we", 0);
    push("rstx.pc", 0); push("rstx.count", 0); push("rstx.illegal", 0); push("rstx.fetch_we", 0);
    set_step(1'b1);
    tick;
    set_step(1'b0);
    pop_chk(32'(reg_we));
    rst = 1'b1;
    #1;
    pop_chk(32'(reg_we)); pop_chk(32'(flag_we));
    @(posedge clk); #1;
    rst = 1'b0;
    pop_chk(32'(pc)); pop_chk(32'(instr_count)); pop_chk(32'(illegal)); pop_chk(32'(reg_we));

`ifdef SINGLE_STEP_EN
    // no step edges: nothing advances; then 3 held pulses retire exactly 3
    run = 1'b1;
    push("step.idle_count", 0);
    repeat (4) tick;
    pop_chk(32'(instr_count));
    push("step.count", 3); push("step.pc", 3);
    for (int p = 0; p < 3; p++) begin
      step = 1'b1;
      repeat (3) tick;
      step = 1'b0;
      repeat (2) tick;
    end
    pop_chk(32'(instr_count)); pop_chk(32'(pc));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
